// File: rtl/exe_muldiv_unit.sv
// ============================================================================
// Module      : exe_muldiv_unit
// Description : Iterative multiply/divide unit for the EXE stage. Runs
//               MULT/MULTU (shift-add) and DIV/DIVU (restoring divide) one
//               radix-2 step per cycle into the architectural HI/LO
//               registers. Also services MTHI/MTLO and requests a pipeline
//               stall while busy and an HI/LO access is pending.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_muldiv_unit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   DIV0_QUOT = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             rd_hilo,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    //   r_wh : product upper half during MULT, partial remainder during DIV
    //   r_wl : multiplier shifting out / product lower half during MULT,
    //          dividend shifting out / quotient shifting in during DIV
    //   r_opb: multiplicand (MULT) or divisor (DIV), magnitude only
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_wh;
    logic [WIDTH-1:0]   r_wl;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // ------------------------------------------------------------------
    // Operand conditioning at accept time
    // ------------------------------------------------------------------
    logic             w_is_muldiv;
    logic             w_is_divop;
    logic             w_is_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_zero;

    assign w_is_muldiv = (op == c_OP_MULT) || (op == c_OP_MULTU) ||
                         (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_is_divop  = (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_is_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
    assign w_a_neg     = w_is_signed & rs_data[WIDTH-1];
    assign w_b_neg     = w_is_signed & rt_data[WIDTH-1];
    assign w_abs_a     = w_a_neg ? -rs_data : rs_data;
    assign w_abs_b     = w_b_neg ? -rt_data : rt_data;
    assign w_div_zero  = w_is_divop && (rt_data == '0);

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    logic [WIDTH:0] w_mul_sum;
    logic [WIDTH:0] w_div_shift;
    logic [WIDTH:0] w_div_diff;
    logic           w_div_fits;

    // Add the multiplicand when the current multiplier bit is set; the carry
    // is kept so the right shift retains the full partial product.
    assign w_mul_sum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opb} : '0);
    // Bring the next dividend bit into the partial remainder and trial-subtract.
    assign w_div_shift = {r_wh, r_wl[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_fits  = ~w_div_diff[WIDTH];

    // ------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod     = {r_wh, r_wl};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_wl : r_wl;
    assign w_rem_fix  = r_neg_r ? -r_wh : r_wh;

    // Control FSM, iterative datapath and HI/LO architectural state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opb    <= '0;
            r_wh     <= '0;
            r_wl     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (flush) begin
            r_state <= c_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_div_zero) begin
                            // Divide-by-zero: result is known, go straight to FIX.
                            r_state  <= c_FIX;
                            r_is_div <= 1'b1;
                            r_neg_q  <= 1'b0;
                            r_neg_r  <= 1'b0;
                            r_wl     <= DIV0_QUOT;
                            r_wh     <= rs_data;
                        end else if (w_is_muldiv) begin
                            r_state  <= c_CALC;
                            r_count  <= '0;
                            r_is_div <= w_is_divop;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_opb    <= w_is_divop ? w_abs_b : w_abs_a;
                            r_wh     <= '0;
                            r_wl     <= w_is_divop ? w_abs_a : w_abs_b;
                        end else if (op == c_OP_MTHI) begin
                            r_hi <= rs_data;
                        end else if (op == c_OP_MTLO) begin
                            r_lo <= rs_data;
                        end
                    end
                end
                c_CALC: begin
                    if (r_is_div) begin
                        r_wh <= w_div_fits ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        r_wl <= {r_wl[WIDTH-2:0], w_div_fits};
                    end else begin
                        r_wh <= w_mul_sum[WIDTH:1];
                        r_wl <= {w_mul_sum[0], r_wl[WIDTH-1:1]};
                    end
                    r_count <= r_count + c_ONE;
                    if (r_count == c_LAST) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    if (r_is_div) begin
                        r_lo <= w_quo_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_count <= '0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state
    // ------------------------------------------------------------------
    assign busy      = (r_state == c_CALC) || (r_state == c_FIX);
    assign done      = (r_state == c_FIX);
    assign stall_req = busy & (start | rd_hilo);
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_exe_muldiv_unit.sv
// ============================================================================
// Module      : tb_exe_muldiv_unit
// Description : Directed self-checking bench for exe_muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_hilo;
    logic        flush;
    logic        busy;
    logic        done;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    exe_muldiv_unit #(
        .WIDTH     (32),
        .DIV0_QUOT (32'hFFFFFFFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .rd_hilo   (rd_hilo),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div op for a single edge and follow it until busy drops.
    // done_at: edge index (start edge = 1) after which done was first seen.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int done_at, output int busy_cycles, output int done_cnt);
        int edge_n;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        tick();
        start = 1'b0;
        edge_n = 1;
        done_at = 0; busy_cycles = 0; done_cnt = 0;
        while (edge_n < 100) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = edge_n;
            end
            if (!busy) break;
            tick();
            edge_n++;
        end
        if (edge_n >= 100) check("timeout", 64'(edge_n), 64'd0);
    endtask

    int d_at, b_cyc, d_cnt, n;
    logic [31:0] save_hi, save_lo;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
        rd_hilo = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_hilo",  {hi, lo}, 64'd0);

        // MULT 7 * -3: done during the 33rd cycle, written at edge 34
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, d_at, b_cyc, d_cnt);
        check("mult_done_at", 64'(d_at), 64'd33);
        check("mult_busy",    64'(b_cyc), 64'd33);
        check("mult_dcnt",    64'(d_cnt), 64'd1);
        check("mult_hilo",    {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

        // MULTU all ones squared
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, d_at, b_cyc, d_cnt);
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        // MULT -4 * -5 = 20
        run_op(3'b000, 32'hFFFFFFFC, 32'hFFFFFFFB, d_at, b_cyc, d_cnt);
        check("mult_negneg", {hi, lo}, 64'h00000000_00000014);

        // DIV -7 / 2 = -3 rem -1
        run_op(3'b010, 32'hFFFFFFF9, 32'd2, d_at, b_cyc, d_cnt);
        check("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        check("div_busy", 64'(b_cyc), 64'd33);

        // DIV 7 / -2 = -3 rem 1
        run_op(3'b010, 32'd7, 32'hFFFFFFFE, d_at, b_cyc, d_cnt);
        check("div_negb_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);

        // DIV overflow -2^31 / -1
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, d_at, b_cyc, d_cnt);
        check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

        // DIVU 100 / 7 = 14 rem 2
        run_op(3'b011, 32'd100, 32'd7, d_at, b_cyc, d_cnt);
        check("divu_hilo", {hi, lo}, 64'h00000002_0000000E);

        // DIVU by zero: straight to FIX
        run_op(3'b011, 32'd100, 32'd0, d_at, b_cyc, d_cnt);
        check("div0_done_at", 64'(d_at), 64'd1);
        check("div0_busy",    64'(b_cyc), 64'd1);
        check("div0_hilo",    {hi, lo}, 64'h00000064_FFFFFFFF);

        // MTHI / MTLO
        start = 1'b1; op = 3'b100; rs_data = 32'h12345678;
        tick();
        check("mthi_hi",   64'(hi), 64'h12345678);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        op = 3'b101; rs_data = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        check("mtlo_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

        // Hazard: DIVU issued, MFHI/MFLO waits behind it
        start = 1'b1; op = 3'b011; rs_data = 32'd1000; rt_data = 32'd7;
        tick();
        start = 1'b0; rd_hilo = 1'b1;
        n = 0; b_cyc = 0;
        while (busy && n < 100) begin
            b_cyc++;
            if (!stall_req) check("haz_stall_hi", 64'(stall_req), 64'd1);
            tick();
            n++;
        end
        check("haz_busy_cycles", 64'(b_cyc), 64'd33);
        check("haz_stall_drop",  64'(stall_req), 64'd0);
        check("haz_hilo",        {hi, lo}, 64'h00000006_0000008E);
        rd_hilo = 1'b0;

        // MTLO held behind a DIVU: applied after the divide result
        start = 1'b1; op = 3'b011; rs_data = 32'd1000; rt_data = 32'd7;
        tick();
        op = 3'b101; rs_data = 32'hCAFEBABE;
        n = 0; b_cyc = 0;
        while (busy && n < 100) begin
            b_cyc++;
            if (!stall_req) check("mt_stall_hi", 64'(stall_req), 64'd1);
            tick();
            n++;
        end
        check("mt_busy_cycles", 64'(b_cyc), 64'd33);
        check("mt_div_result",  {hi, lo}, 64'h00000006_0000008E);
        tick();
        start = 1'b0;
        check("mt_after_div",   {hi, lo}, 64'h00000006_CAFEBABE);

        // Flush at CALC count=10: no update, no done
        save_hi = hi; save_lo = lo;
        start = 1'b1; op = 3'b000; rs_data = 32'd5; rt_data = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        d_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) d_cnt++;
            tick();
        end
        check("flush_no_done", 64'(d_cnt), 64'd0);
        check("flush_hilo",    {hi, lo}, {save_hi, save_lo});

        // Flush together with an MTHI in IDLE suppresses the write
        start = 1'b1; op = 3'b100; rs_data = 32'hDEADBEEF; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_mthi", 64'(hi), 64'(save_hi));

        // Reset mid-CALC
        start = 1'b1; op = 3'b000; rs_data = 32'd5; rt_data = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);

        // Unit still works after the mid-op reset
        run_op(3'b000, 32'd5, 32'd5, d_at, b_cyc, d_cnt);
        check("post_rst_mult", {hi, lo}, 64'h00000000_00000019);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
